// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters,
// with registered ALU inputs and captured ALU outputs on both sides.
module alu_arbiter #(
    parameter int WIDTH = 4,
    parameter int SELW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [SELW-1:0]  req0_sel,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_c,
    output logic             rsp0_carry,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [SELW-1:0]  req1_sel,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_c,
    output logic             rsp1_carry,
    output logic [SELW-1:0]  alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_carry,
    output logic             busy,
    output logic             grant_id
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             grant_id_q, grant_id_d;
    logic [SELW-1:0]  alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_carry_q, rsp_carry_d;
    logic [WIDTH-1:0] rsp0_c_q, rsp0_c_d;
    logic [WIDTH-1:0] rsp1_c_q, rsp1_c_d;
    logic             any_req, pick, rsp_ready_g;

    always_comb begin
        any_req     = req0_valid | req1_valid;
        // Contention goes to the pointer; otherwise whichever side is asking.
        pick        = (req0_valid & req1_valid) ? ptr_q : req1_valid;
        rsp_ready_g = grant_id_q ? rsp1_ready : rsp0_ready;
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        alu_sel_d   = alu_sel_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_carry_d = rsp_carry_q;
        rsp0_c_d    = rsp0_c_q;
        rsp1_c_d    = rsp1_c_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (state_q)
            IDLE: if (any_req) begin
                req0_ready = ~pick;
                req1_ready = pick;
                grant_id_d = pick;
                alu_sel_d  = pick ? req1_sel : req0_sel;
                alu_a_d    = pick ? req1_a : req0_a;
                alu_b_d    = pick ? req1_b : req0_b;
                state_d    = EXEC;
            end
            EXEC: begin
                rsp_valid_d[grant_id_q] = 1'b1;
                rsp_carry_d[grant_id_q] = alu_carry;
                rsp0_c_d = grant_id_q ? rsp0_c_q : alu_c;
                rsp1_c_d = grant_id_q ? alu_c : rsp1_c_q;
                state_d  = RESP;
            end
            RESP: if (rsp_ready_g) begin
                rsp_valid_d[grant_id_q] = 1'b0;
                ptr_d   = ~grant_id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            grant_id_q  <= 1'b0;
            alu_sel_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= '0;
            rsp_carry_q <= '0;
            rsp0_c_q    <= '0;
            rsp1_c_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            alu_sel_q   <= alu_sel_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_carry_q <= rsp_carry_d;
            rsp0_c_q    <= rsp0_c_d;
            rsp1_c_q    <= rsp1_c_d;
        end
    end

    assign alu_sel    = alu_sel_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign grant_id   = grant_id_q;
    assign busy       = (state_q != IDLE);
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_carry = rsp_carry_q[0];
    assign rsp1_carry = rsp_carry_q[1];
    assign rsp0_c     = rsp0_c_q;
    assign rsp1_c     = rsp1_c_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random transactions against a transaction-level
// arbitration/ALU model; the bench also plays the shared ALU.
module tb_alu_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] rv = '0, rq, pv, pr = '0, py;
    logic [1:0] rs [2];
    logic [3:0] ra [2], rb [2], pc [2];
    logic [1:0] alu_sel;
    logic [3:0] alu_a, alu_b, alu_c;
    logic       alu_carry, busy, grant_id;
    int         tests = 0, fails = 0, cyc = 0, last_grant = 0, ptr_m = 0;
    logic [3:0] exp_c [2];
    logic       exp_cy [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign {alu_carry, alu_c} = alu_sel == 2'd0 ? {1'b0, ~alu_b} :
                                alu_sel == 2'd1 ? {1'b0, alu_a & alu_b} :
                                alu_sel == 2'd2 ? {1'b0, alu_a | alu_b} :
                                {1'b0, alu_a} + {1'b0, alu_b};

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(rv[0]), .req0_ready(rq[0]), .req0_sel(rs[0]), .req0_a(ra[0]), .req0_b(rb[0]),
        .rsp0_valid(pv[0]), .rsp0_ready(pr[0]), .rsp0_c(pc[0]), .rsp0_carry(py[0]),
        .req1_valid(rv[1]), .req1_ready(rq[1]), .req1_sel(rs[1]), .req1_a(ra[1]), .req1_b(rb[1]),
        .rsp1_valid(pv[1]), .rsp1_ready(pr[1]), .rsp1_c(pc[1]), .rsp1_carry(py[1]),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_carry(alu_carry),
        .busy(busy), .grant_id(grant_id)
    );

    function automatic logic [4:0] ref_alu(input int sel, input int a, input int b);
        int r;
        if (sel == 0) r = 15 - b;
        else if (sel == 1) r = a & b;
        else if (sel == 2) r = a | b;
        else r = a + b;
        return r[4:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic serve(input bit v0, input bit v1, input int s0, input int a0, input int b0,
                         input int s1, input int a1, input int b1, input int hold, input bit b2b);
        int g, o, s, a, b;
        logic [4:0] r;
        rs[0] = 2'(s0); ra[0] = 4'(a0); rb[0] = 4'(b0);
        rs[1] = 2'(s1); ra[1] = 4'(a1); rb[1] = 4'(b1);
        rv = {v1, v0};
        #1;
        g = (v0 && v1) ? ptr_m : (v1 ? 1 : 0);
        o = 1 - g;
        s = g ? s1 : s0; a = g ? a1 : a0; b = g ? b1 : b0;
        r = ref_alu(s, a, b);
        chk("req_ready_grant", rq, 1 << g);
        if (b2b) chk("b2b_gap", cyc - last_grant, 3);
        last_grant = cyc;
        @(posedge clk); @(negedge clk);
        rv[g] = 1'b0;
        chk("alu_sel", alu_sel, s);
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        chk("grant_id", grant_id, g);
        chk("busy_exec", busy, 1);
        chk("ready_exec", rq, 0);
        pr[g] = (hold == 0);
        @(posedge clk); @(negedge clk);
        chk("rsp_valid", pv, 1 << g);
        chk("rsp_c", pc[g], r[3:0]);
        chk("rsp_carry", py[g], r[4]);
        chk("other_c", pc[o], exp_c[o]);
        chk("other_carry", py[o], exp_cy[o]);
        exp_c[g] = r[3:0]; exp_cy[g] = r[4];
        repeat (hold) begin
            @(posedge clk); @(negedge clk);
            chk("hold_valid", pv, 1 << g);
            chk("hold_c", pc[g], r[3:0]);
            chk("hold_ready", rq, 0);
            chk("hold_busy", busy, 1);
        end
        pr[g] = 1'b1;
        @(posedge clk); @(negedge clk);
        pr[g] = 1'b0;
        chk("done_valid", pv, 0);
        chk("done_busy", busy, 0);
        ptr_m = o;
    endtask

    initial begin
        exp_c[0] = '0; exp_c[1] = '0; exp_cy[0] = 1'b0; exp_cy[1] = 1'b0;
        rs[0] = '0; rs[1] = '0; ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_alu", {alu_sel, alu_a, alu_b}, 0);
        chk("rst_rsp", {pv, py, pc[0], pc[1]}, 0);
        chk("rst_grant", grant_id, 0);
        @(negedge clk); rst = 1'b0;
        // single request, logic AND
        serve(1, 0, 1, 'hC, 'hA, 0, 0, 0, 0, 0);
        chk("and_c", pc[0], 4'h8);
        // add with carry out
        serve(0, 1, 0, 0, 0, 3, 'h9, 'h8, 0, 0);
        chk("add_c", pc[1], 4'h1);
        chk("add_carry", py[1], 1);
        // contention: grants alternate
        for (int i = 0; i < 4; i++) serve(1, 1, 2, 'h3, 'h4, 0, 0, 'h5, 0, 0);
        chk("cont_c0", pc[0], 4'h7);
        chk("cont_c1", pc[1], 4'hA);
        // backpressure on requester 0 with requester 1 waiting, then requester 1 served
        serve(1, 1, 2, 'h1, 'h2, 1, 'hF, 'h6, 5, 0);
        serve(0, 1, 0, 0, 0, 1, 'hF, 'h6, 0, 0);
        chk("bp_next_c1", pc[1], 4'h6);
        // back-to-back from requester 0 only
        serve(1, 0, 3, 'hF, 'hF, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) serve(1, 0, i, 4 + i, 9 - i, 0, 0, 0, 0, 1);
        // random traffic
        for (int i = 0; i < 60; i++) begin
            int v;
            v = $urandom_range(1, 3);
            serve(v[0], v[1], $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 2), 0);
            rv = '0;
        end
        // asynchronous reset in EXEC abandons the operation
        rs[0] = 2'd3; ra[0] = 4'h5; rb[0] = 4'h6; rv[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        rv[0] = 1'b0;
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_alu", {alu_sel, alu_a, alu_b}, 0);
        chk("arst_rsp", {pv, py, pc[0], pc[1]}, 0);
        chk("arst_grant", grant_id, 0);
        chk("arst_ready", rq, 0);
        @(negedge clk); rst = 1'b0;
        ptr_m = 0;
        exp_c[0] = '0; exp_c[1] = '0; exp_cy[0] = 1'b0; exp_cy[1] = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        serve(0, 1, 0, 0, 0, 1, 'hC, 'hA, 0, 0);
        chk("post_rst_c1", pc[1], 4'h8);
        chk("post_rst_cy1", py[1], 0);
        // pointer back at 0 after reset: requester 0 wins contention
        serve(1, 1, 2, 'h3, 'h4, 0, 0, 'h5, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
